// File: rtl/multicycle_controller.sv
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle MIPS control FSM driving data_path. The bne opcode
//               is decoded only when BNE_SUPPORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       ZERO,
  output logic       pc_write,
  output logic       IRwrite,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       jal_rej,
  output logic       pc_to_reg,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       AluSrcA,
  output logic [3:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [2:0] pc_src,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;

  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;
  localparam logic [5:0] c_FN_JR    = 6'b001000;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_SLT  = 3'b100;

  localparam logic [3:0] c_SRCB_REG = 4'b0001;
  localparam logic [3:0] c_SRCB_4   = 4'b0010;
  localparam logic [3:0] c_SRCB_IMM = 4'b0100;
  localparam logic [3:0] c_SRCB_BRT = 4'b1000;

  localparam logic [2:0] c_PC_ALU   = 3'd0;
  localparam logic [2:0] c_PC_ALUOUT= 3'd1;
  localparam logic [2:0] c_PC_JUMP  = 3'd2;
  localparam logic [2:0] c_PC_REG   = 3'd3;

  state_t r_state;

  // Unlisted R-type functions fall back to add so the write-back stays defined.
  function automatic logic [2:0] rtype_aluop(input logic [5:0] fn);
    case (fn)
      c_FN_ADD: rtype_aluop = c_ALU_ADD;
      c_FN_SUB: rtype_aluop = c_ALU_SUB;
      c_FN_AND: rtype_aluop = c_ALU_AND;
      c_FN_OR:  rtype_aluop = c_ALU_OR;
      c_FN_SLT: rtype_aluop = c_ALU_SLT;
      default:  rtype_aluop = c_ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] itype_aluop(input logic [5:0] op);
    case (op)
      c_OP_SLTI: itype_aluop = c_ALU_SLT;
      c_OP_ANDI: itype_aluop = c_ALU_AND;
      default:   itype_aluop = c_ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            c_OP_RTYPE:                      r_state <= (func == c_FN_JR) ? S_JR : S_RTEX;
            c_OP_LW, c_OP_SW:                r_state <= S_MEMADR;
            c_OP_ADDI, c_OP_SLTI, c_OP_ANDI: r_state <= S_IEX;
`ifdef BNE_SUPPORT_EN
            c_OP_BEQ, c_OP_BNE:              r_state <= S_BR;
`else
            c_OP_BEQ:                        r_state <= S_BR;
`endif
            c_OP_J:                          r_state <= S_JMP;
            c_OP_JAL:                        r_state <= S_JAL;
            default:                         r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_RTEX:   r_state <= S_RTWB;
        S_IEX:    r_state <= S_IWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign state = r_state;

  always_comb begin
    pc_write   = 1'b0;
    IRwrite    = 1'b0;
    IorD       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    jal_rej    = 1'b0;
    pc_to_reg  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = c_SRCB_REG;
    AluOp      = c_ALU_ADD;
    pc_src     = c_PC_ALU;

    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        IRwrite  = 1'b1;
        AluSrcB  = c_SRCB_4;
        pc_write = 1'b1;
      end
      S_DECODE: AluSrcB = c_SRCB_BRT;
      S_MEMADR: begin
        AluSrcA = 1'b1;
        AluSrcB = c_SRCB_IMM;
      end
      S_MEMRD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      S_RTEX: begin
        AluSrcA = 1'b1;
        AluOp   = rtype_aluop(func);
      end
      S_RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_IEX: begin
        AluSrcA = 1'b1;
        AluSrcB = c_SRCB_IMM;
        AluOp   = itype_aluop(opcode);
      end
      S_IWB: reg_write = 1'b1;
      S_BR: begin
        AluSrcA = 1'b1;
        AluOp   = c_ALU_SUB;
        pc_src  = c_PC_ALUOUT;
`ifdef BNE_SUPPORT_EN
        pc_write = (opcode == c_OP_BNE) ? ~ZERO : ZERO;
`else
        pc_write = ZERO;
`endif
      end
      S_JMP: begin
        pc_src   = c_PC_JUMP;
        pc_write = 1'b1;
      end
      // PC already holds PC+4 here, so $31 gets the correct return address.
      S_JAL: begin
        pc_src    = c_PC_JUMP;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        jal_rej   = 1'b1;
        pc_to_reg = 1'b1;
      end
      S_JR: begin
        pc_src   = c_PC_REG;
        pc_write = 1'b1;
      end
      default: ;
    endcase

    // Reset must kill every strobe at once, even mid-instruction.
    if (!rst) begin
      pc_write   = 1'b0;
      IRwrite    = 1'b0;
      IorD       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      jal_rej    = 1'b0;
      pc_to_reg  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      AluSrcA    = 1'b0;
      AluSrcB    = 4'b0000;
      AluOp      = 3'b000;
      pc_src     = 3'b000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       ZERO;
  logic       pc_write, IRwrite, IorD, mem_read, mem_write, reg_dst, jal_rej;
  logic       pc_to_reg, mem_to_reg, reg_write, AluSrcA;
  logic [3:0] AluSrcB;
  logic [2:0] AluOp;
  logic [2:0] pc_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ZERO(ZERO),
    .pc_write(pc_write), .IRwrite(IRwrite), .IorD(IorD), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .jal_rej(jal_rej),
    .pc_to_reg(pc_to_reg), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .pc_src(pc_src),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [20:0] ctl = {pc_write, IRwrite, IorD, mem_read, mem_write, reg_dst, jal_rej,
                     pc_to_reg, mem_to_reg, reg_write, AluSrcA, AluSrcB, AluOp, pc_src};

  function automatic logic [20:0] mk(input logic pcw, input logic irw, input logic iord,
                                     input logic mr, input logic mw, input logic rd,
                                     input logic jal, input logic ptr, input logic mtr,
                                     input logic rw, input logic asa, input logic [3:0] asb,
                                     input logic [2:0] aop, input logic [2:0] psrc);
    return {pcw, irw, iord, mr, mw, rd, jal, ptr, mtr, rw, asa, asb, aop, psrc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] exp_state, input logic [20:0] exp_ctl);
    chk({tag, ".state"}, 32'(state), 32'(exp_state));
    chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [20:0] e_zero, e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr;
  logic [20:0] e_rtex_sub, e_rtex_slt, e_rtwb, e_iex_slt, e_iwb, e_br_t, e_br_f;
  logic [20:0] e_jmp, e_jal, e_jr;

  initial begin
    //               pcw irw iod mr mw rd jl ptr mtr rw asa  asb      aop     psrc
    e_zero     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 3'd0);
    e_fetch    = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 3'b000, 3'd0);
    e_decode   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 3'b000, 3'd0);
    e_memadr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 3'b000, 3'd0);
    e_memrd    = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 3'b000, 3'd0);
    e_memwb    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0001, 3'b000, 3'd0);
    e_memwr    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 3'b000, 3'd0);
    e_rtex_sub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 3'b001, 3'd0);
    e_rtex_slt = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 3'b100, 3'd0);
    e_rtwb     = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'b0001, 3'b000, 3'd0);
    e_iex_slt  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100, 3'b100, 3'd0);
    e_iwb      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 3'b000, 3'd0);
    e_br_t     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 3'b001, 3'd1);
    e_br_f     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0001, 3'b001, 3'd1);
    e_jmp      = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 3'b000, 3'd2);
    e_jal      = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 4'b0001, 3'b000, 3'd2);
    e_jr       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 3'b000, 3'd3);

    rst = 1'b0; opcode = 6'b0; func = 6'b0; ZERO = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    #1;
    chk_st("reset", 4'd0, e_zero);
    rst = 1'b1;
    #1;
    chk_st("fetch_after_reset", 4'd0, e_fetch);

    // lw: 0-1-2-3-4-0
    opcode = 6'b100011;
    step(); chk_st("lw.decode", 4'd1, e_decode);
    step(); chk_st("lw.memadr", 4'd2, e_memadr);
    step(); chk_st("lw.memrd", 4'd3, e_memrd);
    step(); chk_st("lw.memwb", 4'd4, e_memwb);
    step(); chk_st("lw.fetch", 4'd0, e_fetch);

    // sw: 0-1-2-5-0
    opcode = 6'b101011;
    step(); chk_st("sw.decode", 4'd1, e_decode);
    step(); chk_st("sw.memadr", 4'd2, e_memadr);
    step(); chk_st("sw.memwr", 4'd5, e_memwr);
    step(); chk_st("sw.fetch", 4'd0, e_fetch);

    // R-type sub
    opcode = 6'b000000; func = 6'b100010;
    step(); chk_st("sub.decode", 4'd1, e_decode);
    step(); chk_st("sub.rtex", 4'd6, e_rtex_sub);
    step(); chk_st("sub.rtwb", 4'd7, e_rtwb);
    step(); chk_st("sub.fetch", 4'd0, e_fetch);

    // R-type slt
    func = 6'b101010;
    step(); step(); chk_st("slt.rtex", 4'd6, e_rtex_slt);
    step(); step(); chk("slt.fetch", 32'(state), 32'd0);

    // jr
    func = 6'b001000;
    step(); chk_st("jr.decode", 4'd1, e_decode);
    step(); chk_st("jr.jr", 4'd13, e_jr);
    step(); chk_st("jr.fetch", 4'd0, e_fetch);

    // slti
    opcode = 6'b001010; func = 6'b000000;
    step(); step(); chk_st("slti.iex", 4'd8, e_iex_slt);
    step(); chk_st("slti.iwb", 4'd9, e_iwb);
    step(); chk("slti.fetch", 32'(state), 32'd0);

    // beq: pc_write follows ZERO within the BR cycle
    opcode = 6'b000100;
    step(); step();
    ZERO = 1'b1; #1; chk_st("beq.z1", 4'd10, e_br_t);
    ZERO = 1'b0; #1; chk_st("beq.z0", 4'd10, e_br_f);
    step(); chk("beq.fetch", 32'(state), 32'd0);

    // bne
    opcode = 6'b000101;
    step(); chk_st("bne.decode", 4'd1, e_decode);
    step();
`ifdef BNE_SUPPORT_EN
    ZERO = 1'b1; #1; chk_st("bne.z1", 4'd10, e_br_f);
    ZERO = 1'b0; #1; chk_st("bne.z0", 4'd10, e_br_t);
    step();
`endif
    chk_st("bne.fetch", 4'd0, e_fetch);

    // j
    opcode = 6'b000010;
    step(); step(); chk_st("j.jmp", 4'd11, e_jmp);
    step(); chk("j.fetch", 32'(state), 32'd0);

    // jal
    opcode = 6'b000011;
    step(); step(); chk_st("jal.jal", 4'd12, e_jal);
    step(); chk("jal.fetch", 32'(state), 32'd0);

    // illegal opcode: DECODE then straight back to FETCH
    opcode = 6'b111111;
    step(); chk_st("ill.decode", 4'd1, e_decode);
    step(); chk_st("ill.fetch", 4'd0, e_fetch);

    // reset asserted in the middle of lw (MEMRD)
    opcode = 6'b100011;
    step(); step(); step(); chk_st("lw2.memrd", 4'd3, e_memrd);
    rst = 1'b0; #1;
    chk_st("midrst.now", 4'd0, e_zero);
    step(); chk_st("midrst.hold", 4'd0, e_zero);
    rst = 1'b1; #1;
    chk_st("midrst.release", 4'd0, e_fetch);
    step(); chk_st("midrst.decode", 4'd1, e_decode);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
